// File: rtl/ahb_arbiter_mux.sv
// Round-robin AHB arbiter that shares one slave port among up to four masters.
// Address phase follows the current grant; write data and responses follow the data-phase owner.
module ahb_arbiter_mux #(
  parameter int NUM_MST     = 2,
  parameter int DEFAULT_MST = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MST-1:0]     m_hbusreq_i,
  input  logic [NUM_MST-1:0]     m_hlock_i,
  input  logic [NUM_MST*32-1:0]  m_haddr_i,
  input  logic [NUM_MST*2-1:0]   m_htrans_i,
  input  logic [NUM_MST-1:0]     m_hwrite_i,
  input  logic [NUM_MST*3-1:0]   m_hsize_i,
  input  logic [NUM_MST*3-1:0]   m_hburst_i,
  input  logic [NUM_MST*4-1:0]   m_hprot_i,
  input  logic [NUM_MST*32-1:0]  m_hwdata_i,
  output logic [NUM_MST-1:0]     m_hgrant_o,
  output logic [NUM_MST-1:0]     m_hready_o,
  output logic [NUM_MST*32-1:0]  m_hrdata_o,
  output logic [NUM_MST*2-1:0]   m_hresp_o,
  output logic [31:0]            s_haddr_o,
  output logic [1:0]             s_htrans_o,
  output logic                   s_hwrite_o,
  output logic [2:0]             s_hsize_o,
  output logic [2:0]             s_hburst_o,
  output logic [3:0]             s_hprot_o,
  output logic [31:0]            s_hwdata_o,
  output logic                   s_hready_o,
  output logic [3:0]             s_hmaster_o,
  output logic                   s_hmastlock_o,
  input  logic [31:0]            s_hrdata_i,
  input  logic [1:0]             s_hresp_i,
  input  logic                   s_hreadyout_i
);

  localparam logic [1:0] DEF_IDX  = 2'(DEFAULT_MST);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic [1:0]  grant_q, downer_q, rr_q;
  logic [4:0]  beats_q, beats_d;

  logic [3:0]  req_a, lock_a, write_a;
  logic [31:0] addr_a  [4];
  logic [31:0] wdata_a [4];
  logic [1:0]  trans_a [4];
  logic [2:0]  size_a  [4];
  logic [2:0]  burst_a [4];
  logic [3:0]  prot_a  [4];

  logic [1:0]  own_trans;
  logic [2:0]  own_burst;
  logic        own_lock;
  logic        hold;
  logic        found;
  logic [1:0]  rr_pick, cand;

  // Unused master slots are padded to zero so every lookup can index all four.
  for (genvar k = 0; k < 4; k++) begin : g_slot
    if (k < NUM_MST) begin : g_used
      assign req_a[k]   = m_hbusreq_i[k];
      assign lock_a[k]  = m_hlock_i[k];
      assign write_a[k] = m_hwrite_i[k];
      assign addr_a[k]  = m_haddr_i[k*32 +: 32];
      assign wdata_a[k] = m_hwdata_i[k*32 +: 32];
      assign trans_a[k] = m_htrans_i[k*2 +: 2];
      assign size_a[k]  = m_hsize_i[k*3 +: 3];
      assign burst_a[k] = m_hburst_i[k*3 +: 3];
      assign prot_a[k]  = m_hprot_i[k*4 +: 4];
    end else begin : g_pad
      assign req_a[k]   = 1'b0;
      assign lock_a[k]  = 1'b0;
      assign write_a[k] = 1'b0;
      assign addr_a[k]  = 32'h0;
      assign wdata_a[k] = 32'h0;
      assign trans_a[k] = T_IDLE;
      assign size_a[k]  = 3'h0;
      assign burst_a[k] = 3'h0;
      assign prot_a[k]  = 4'h0;
    end
  end

  for (genvar k = 0; k < NUM_MST; k++) begin : g_out
    assign m_hgrant_o[k]          = (grant_q == 2'(k));
    assign m_hready_o[k]          = s_hreadyout_i;
    assign m_hrdata_o[k*32 +: 32] = s_hrdata_i;
    assign m_hresp_o[k*2 +: 2]    = (downer_q == 2'(k)) ? s_hresp_i : 2'b00;
  end

  assign own_trans = trans_a[grant_q];
  assign own_burst = burst_a[grant_q];
  assign own_lock  = lock_a[grant_q];

  // INCR bursts keep beats_q at 0, so SEQ/BUSY holds until the master leaves the burst.
  assign hold = own_lock
             || (own_trans == T_NONSEQ && own_burst != 3'd0)
             || ((own_trans == T_SEQ || own_trans == T_BUSY) && beats_q != 5'd1);

  // Scanning modulo 4 over zero-padded requests preserves round-robin order for any NUM_MST.
  always_comb begin
    found   = 1'b0;
    rr_pick = DEF_IDX;
    cand    = rr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = rr_q + 2'(i);
      if (!found && req_a[cand]) begin
        found   = 1'b1;
        rr_pick = cand;
      end
    end
  end

  always_comb begin
    beats_d = beats_q;
    if (own_trans == T_NONSEQ) begin
      case (own_burst)
        3'd2, 3'd3: beats_d = 5'd3;
        3'd4, 3'd5: beats_d = 5'd7;
        3'd6, 3'd7: beats_d = 5'd15;
        default:    beats_d = 5'd0;
      endcase
    end else if (own_trans == T_SEQ && beats_q != 5'd0) begin
      beats_d = beats_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q  <= DEF_IDX;
      downer_q <= DEF_IDX;
      rr_q     <= DEF_IDX;
      beats_q  <= 5'd0;
    end else if (s_hreadyout_i) begin
      downer_q <= grant_q;
      beats_q  <= beats_d;
      if (!hold) begin
        if (found) begin
          grant_q <= rr_pick;
          rr_q    <= rr_pick;
        end else begin
          grant_q <= DEF_IDX;
        end
      end
    end
  end

  assign s_haddr_o     = addr_a[grant_q];
  assign s_htrans_o    = rst_i ? T_IDLE : own_trans;
  assign s_hwrite_o    = write_a[grant_q];
  assign s_hsize_o     = size_a[grant_q];
  assign s_hburst_o    = own_burst;
  assign s_hprot_o     = prot_a[grant_q];
  assign s_hwdata_o    = wdata_a[downer_q];
  assign s_hready_o    = s_hreadyout_i;
  assign s_hmaster_o   = {2'b00, grant_q};
  assign s_hmastlock_o = !rst_i && own_lock && (own_trans != T_IDLE);

endmodule

// File: doc/ahb_arbiter_mux.md
# ahb_arbiter_mux

Round-robin AHB arbiter and address/data multiplexer that shares one AHB slave port between up to four AHB masters. Its first use is sharing a single `mem_ahb` instance between the data-side and instruction-side OBI-to-AHB bridges of the CV32E40P testbench. It grants the bus, routes the address and control phase by the current grant, and routes write data, read data and response by the data-phase owner. It holds ownership across locked sequences and bursts.

## Interface

**Parameters**
- `NUM_MST`, default 2: number of masters, legal range 2..4.
- `DEFAULT_MST`, default 0: master granted when nobody requests, and after reset.

**Ports** (per-master buses are packed, with master *k* at slice *k*)
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `m_hbusreq_i` in NUM_MST: bus request per master.
- `m_hlock_i` in NUM_MST: locked-transfer request per master.
- `m_haddr_i` in NUM_MST*32: address.
- `m_htrans_i` in NUM_MST*2: transfer type.
- `m_hwrite_i` in NUM_MST: direction.
- `m_hsize_i` in NUM_MST*3: transfer size.
- `m_hburst_i` in NUM_MST*3: burst type.
- `m_hprot_i` in NUM_MST*4: protection.
- `m_hwdata_i` in NUM_MST*32: write data.
- `m_hgrant_o` out NUM_MST: one-hot grant.
- `m_hready_o` out NUM_MST: HREADY to each master.
- `m_hrdata_o` out NUM_MST*32: read data to each master.
- `m_hresp_o` out NUM_MST*2: response to each master.
- `s_haddr_o`, `s_htrans_o`, `s_hwrite_o`, `s_hsize_o`, `s_hburst_o`, `s_hprot_o` out 32/2/1/3/3/4: muxed address phase.
- `s_hwdata_o` out 32: muxed write data.
- `s_hready_o` out 1: HREADYin to the slave. Equals `s_hreadyout_i`.
- `s_hmaster_o` out 4: index of the address-phase owner.
- `s_hmastlock_o` out 1: the owner's locked sequence is in progress.
- `s_hrdata_i`, `s_hresp_i`, `s_hreadyout_i` in 32/2/1: slave data-phase return.

## Operation

**State**
- `grant_q`: address-phase owner index.
- `downer_q`: data-phase owner index.
- `rr_q`: last master granted on a real request.
- `beats_q`: 5-bit count of remaining beats in a fixed-length burst.

**Address phase**
- All `s_*` address/control outputs come from master `grant_q`.
- `m_hgrant_o = onehot(grant_q)`.
- `s_hmaster_o = grant_q`, zero-extended.

**Data phase**
- `s_hwdata_o` comes from master `downer_q`.
- Every master receives `m_hrdata_o = s_hrdata_i` and `m_hready_o = s_hreadyout_i` (shared HREADY, as AHB requires).
- `m_hresp_o` is `s_hresp_i` for `downer_q` and OKAY for all other masters.

**Hold conditions.** Re-arbitration is blocked while any of these is true for the owner:
- `m_hlock_i` is 1.
- `m_htrans_i` is NONSEQ with `hburst` ≠ SINGLE.
- `m_htrans_i` is SEQ or BUSY and `beats_q` ≠ 1. For INCR (undefined length) bursts, `beats_q` stays 0 and the hold lasts while SEQ/BUSY continues.

**Burst counter**, on an accepted transfer (HREADY=1):
- NONSEQ loads `beats_q` with beats−1 for 4/8/16-beat bursts (3, 7, 15), or 0 otherwise.
- SEQ decrements `beats_q` when it is nonzero.

**Arbitration**
- If not blocked and `s_hreadyout_i` = 1, the next grant is the first requesting master after `rr_q` in round-robin order.
- If no master requests, the next grant is `DEFAULT_MST`.
- `rr_q` updates only on a granted real request.

**Lock and split**
- `s_hmastlock_o` = owner's `m_hlock_i` AND owner's `htrans` ≠ IDLE.
- SPLIT and RETRY are not supported. They are forwarded to the owner unchanged and cause no re-arbitration.

## Timing

**Reset values.** While `rst_i` = 1 (asynchronous):
- `grant_q` = `downer_q` = `rr_q` = `DEFAULT_MST`, `beats_q` = 0.
- Hence `m_hgrant_o = onehot(DEFAULT_MST)` and `s_hmaster_o = DEFAULT_MST`.
- `s_hmastlock_o` = 0. `s_htrans_o` is forced IDLE.
- Data-path outputs follow their mux inputs.

**Register updates**
- `grant_q`, `downer_q`, `rr_q` and `beats_q` update only on rising edges with `s_hreadyout_i` = 1.
- `downer_q <= grant_q` on those edges, so the data phase lags the address phase by one accepted transfer.

**Grant latency.** A request raised in cycle N with HREADY = 1 and no hold asserts `m_hgrant_o` after the edge ending cycle N. The master drives NONSEQ in cycle N+1 at the earliest.

**Boundary conditions**
- Wait states (HREADY = 0) freeze all state, including during a two-cycle ERROR response.
- A request withdrawn before the grant edge is ignored.
- Simultaneous requests follow the round-robin rule.
- A request from the current owner alone keeps the grant.
- Reset mid-burst abandons the burst with no completion beat.

## Test plan

1. **Reset.** Assert `rst_i` for 3 cycles with `DEFAULT_MST` = 0 and NUM_MST = 2 → `m_hgrant_o` = 2'b01, `s_hmaster_o` = 0, `s_htrans_o` = IDLE, `s_hmastlock_o` = 0.
2. **Fair sharing.** Both masters hold `hbusreq` and issue SINGLE NONSEQ transfers with HREADY = 1 → grants alternate 1, 0, 1, 0. Each master's `s_haddr_o` (e.g. 0x100 / 0x2000) appears on the slave only while it is granted.
3. **Burst hold.** M1 issues INCR4 at 0x40 while M0 requests → grant stays 1 for addresses 0x40, 0x44, 0x48, 0x4C, then moves to 0 on the edge accepting 0x4C.
4. **Wait states.** M0 read with `s_hreadyout_i` low for 3 cycles and `s_hrdata_i` = 0xDEADBEEF → grant unchanged. M0 sees 0xDEADBEEF with HREADY = 1. `m_hresp_o` for M1 stays OKAY even when the slave returns ERROR.
5. **Lock.** M0 holds `hlock` over two SINGLE writes while M1 requests → `s_hmastlock_o` = 1 and there is no handoff until `hlock` drops. Grant goes to M1 one edge later.
6. **Reset mid-burst.** Assert `rst_i` during beat 2 of an INCR8 from M1 → immediate `m_hgrant_o` = 2'b01 and `beats_q` = 0. Normal arbitration follows after release.
